serial_result_reader: RTL and testbench

- Reader side of the serial adder datapath. Collects the LSB-first sum bit stream leaving the full-adder/1-bit-memory loop, plus the final carry, into a parallel word.
- Bit counter plus a 3-state FSM. Start/done handshake toward the controller.
- Sits between the serial full adder output and the display/control logic.

---
 rtl/serial_result_reader.sv | 146 ++++++++++++++
 tb/tb_serial_result_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_result_reader.sv
// serial_result_reader
//   Reader side of the serial adder datapath. Collects the LSB-first sum bit
//   stream from the full-adder / carry-memory loop into a parallel word. It also
//   captures the final carry. A START/DONE/ACK handshake connects it to the
//   controller.
//
// Parameters:
//   WIDTH      serial bits per result word (2..32)
//
// Ports:
//   CLK2       system clock, rising edge
//   RESET      asynchronous active-high reset
//   CE         bit-valid; SUMA_IN is sampled only when CE=1 in SHIFT
//   START      1-cycle request to begin a new word
//   SUMA_IN    serial sum bit, LSB first
//   CARRY_IN   carry from the 1-bit carry memory, used on the last bit
//   ACK        controller acknowledges the completed result
//   BUSY       high while shifting
//   DONE       high while holding a valid result
//   RESULT     collected parallel sum
//   CARRY_OUT  final carry captured with the last bit
//   PARIDAD    XOR-reduction of the captured word (only with PARIDAD_EN)
//
// Optional feature macro: PARIDAD_EN adds the PARIDAD output.

module serial_result_reader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK2,
  input  logic             RESET,
  input  logic             CE,
  input  logic             START,
  input  logic             SUMA_IN,
  input  logic             CARRY_IN,
  input  logic             ACK,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY_OUT
`ifdef PARIDAD_EN
  ,
  output logic             PARIDAD
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q, carry_d;
  logic              capture;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shreg_d = shreg_q;
    result_d = result_q;
    carry_d = carry_q;
    capture = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StShift;
          count_d = '0;
          shreg_d = '0;
        end
      end
      StShift: begin
        if (CE) begin
          // New bits enter at the MSB, so after WIDTH shifts bit k sits at position k.
          shreg_d = {SUMA_IN, shreg_q[WIDTH-1:1]};
          count_d = count_q + CntW'(1);
          if (count_q == LastIdx) begin
            capture = 1'b1;
            result_d = shreg_d;
            carry_d = CARRY_IN;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (ACK) begin
          if (START) begin
            // Acknowledge and restart in one cycle skips IDLE.
            state_d = StShift;
            count_d = '0;
            shreg_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      count_q <= '0;
      shreg_q <= '0;
      result_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
      result_q <= result_d;
      carry_q <= carry_d;
    end
  end

`ifdef PARIDAD_EN
  logic parity_q;

  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      parity_q <= 1'b0;
    end else if (capture) begin
      parity_q <= ^result_d;
    end
  end

  assign PARIDAD = parity_q;
`else
  // Capture strobe only feeds the parity register.
  logic unused_capture;
  assign unused_capture = capture;
`endif

  assign BUSY = (state_q == StShift);
  assign DONE = (state_q == StHold);
  assign RESULT = result_q;
  assign CARRY_OUT = carry_q;

endmodule

// File: tb/tb_serial_result_reader.sv
// Self-checking bench for serial_result_reader (WIDTH=8). Outputs are compared
// against a word-level reference model that collects sampled bits in a queue
// and rebuilds the word arithmetically once WIDTH bits have arrived.

module tb_serial_result_reader;

  localparam int unsigned W = 8;

  logic         CLK2 = 1'b0;
  logic         RESET;
  logic         CE;
  logic         START;
  logic         SUMA_IN;
  logic         CARRY_IN;
  logic         ACK;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RESULT;
  logic         CARRY_OUT;
`ifdef PARIDAD_EN
  logic         PARIDAD;
`endif

  serial_result_reader #(
    .WIDTH(W)
  ) dut (
    .CLK2     (CLK2),
    .RESET    (RESET),
    .CE       (CE),
    .START    (START),
    .SUMA_IN  (SUMA_IN),
    .CARRY_IN (CARRY_IN),
    .ACK      (ACK),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT),
    .CARRY_OUT(CARRY_OUT)
`ifdef PARIDAD_EN
    ,
    .PARIDAD  (PARIDAD)
`endif
  );

  always #5 CLK2 = ~CLK2;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = idle, 1 = collecting, 2 = result held.
  int           m_mode;
  bit           m_bits[$];
  logic [W-1:0] m_result;
  logic         m_carry;

  function automatic logic [10:0] m_vec();
    return {m_mode == 1, m_mode == 2, m_carry, m_result};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_bits.delete();
    m_result = '0;
    m_carry = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] w;
    if (RESET) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (START) begin
        m_mode = 1;
        m_bits.delete();
      end
      1: if (CE) begin
        m_bits.push_back(SUMA_IN);
        if (m_bits.size() == W) begin
          w = '0;
          for (int i = 0; i < W; i++) w = w + (W'(m_bits[i]) << i);
          m_result = w;
          m_carry = CARRY_IN;
          m_mode = 2;
        end
      end
      default: if (ACK) begin
        m_mode = START ? 1 : 0;
        m_bits.delete();
      end
    endcase
  endtask

  task automatic drive(input logic st, input logic ce, input logic s, input logic c,
                       input logic ack);
    START = st;
    CE = ce;
    SUMA_IN = s;
    CARRY_IN = c;
    ACK = ack;
  endtask

  // Advance one edge; returns 1 ns after the edge with the model updated.
  task automatic tick();
    @(posedge CLK2);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    @(posedge CLK2);
    #4;
    RESET = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({BUSY, DONE, CARRY_OUT, RESULT} !== 11'h000) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", {BUSY, DONE, CARRY_OUT, RESULT}, 11'h000);
    end
    @(negedge CLK2);
    RESET = 1'b0;
    tick();
    checks++;
    if ({BUSY, DONE, CARRY_OUT, RESULT} !== 11'h000) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", {BUSY, DONE, CARRY_OUT, RESULT},
               11'h000);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] word;
    word = 8'hA5;
    drive(1, 0, 0, 0, 0);
    tick();
    checks++;
    if ({BUSY, DONE} !== 2'b10) begin
      errors++;
      $display("FAIL basic_start: busy/done got %b expected 10", {BUSY, DONE});
    end
    for (int i = 0; i < W; i++) begin
      drive(0, 1, word[i], (i == W - 1), 0);
      tick();
      checks++;
      if ({BUSY, DONE, CARRY_OUT, RESULT} !== m_vec()) begin
        errors++;
        $display("FAIL basic_bit%0d: got %h expected %h", i, {BUSY, DONE, CARRY_OUT, RESULT},
                 m_vec());
      end
    end
    checks++;
    if ({DONE, CARRY_OUT, RESULT} !== {1'b1, 1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL basic_word: done/carry/result got %h expected %h",
               {DONE, CARRY_OUT, RESULT}, {1'b1, 1'b1, 8'hA5});
    end
`ifdef PARIDAD_EN
    checks++;
    if (PARIDAD !== 1'b0) begin
      errors++;
      $display("FAIL basic_parity: got %b expected 0", PARIDAD);
    end
`endif
    drive(0, 0, 0, 0, 1);
    tick();
    checks++;
    if ({BUSY, DONE, RESULT} !== {2'b00, 8'hA5}) begin
      errors++;
      $display("FAIL basic_ack: got %h expected %h", {BUSY, DONE, RESULT}, {2'b00, 8'hA5});
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] word;
    int           edges;
    int           sent;
    int           stalls;
    word = 8'hA5;
    edges = 0;
    sent = 0;
    stalls = 0;
    drive(1, 0, 0, 0, 0);
    tick();
    while (DONE !== 1'b1 && edges < 40) begin
      if (sent == 4 && stalls < 3) begin
        drive(0, 0, ~word[sent], 1, 0);
        stalls++;
      end else begin
        drive(0, 1, word[sent], (sent == W - 1), 0);
        sent++;
      end
      tick();
      edges++;
      checks++;
      if ({BUSY, DONE, CARRY_OUT, RESULT} !== m_vec()) begin
        errors++;
        $display("FAIL stall_cycle%0d: got %h expected %h", edges,
                 {BUSY, DONE, CARRY_OUT, RESULT}, m_vec());
      end
    end
    checks++;
    if (edges !== W + 3) begin
      errors++;
      $display("FAIL stall_latency: done after %0d edges expected %0d", edges, W + 3);
    end
    checks++;
    if (RESULT !== 8'hA5) begin
      errors++;
      $display("FAIL stall_word: got %h expected a5", RESULT);
    end
  endtask

  // Entered in HOLD with 0xA5.
  task automatic test_handshake();
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 1, 1, 0, 0);
      tick();
      checks++;
      if ({BUSY, DONE, RESULT} !== {2'b01, 8'hA5}) begin
        errors++;
        $display("FAIL handshake_wait%0d: got %h expected %h", i, {BUSY, DONE, RESULT},
                 {2'b01, 8'hA5});
      end
    end
    drive(0, 0, 0, 0, 1);
    tick();
    checks++;
    if ({BUSY, DONE, RESULT} !== {2'b00, 8'hA5}) begin
      errors++;
      $display("FAIL handshake_ack: got %h expected %h", {BUSY, DONE, RESULT}, {2'b00, 8'hA5});
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] word;
    word = 8'hA5;
    drive(1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < W; i++) begin
      drive(0, 1, word[i], 1, 0);
      tick();
    end
    drive(1, 0, 0, 0, 1);
    tick();
    checks++;
    if ({BUSY, DONE, RESULT} !== {2'b10, 8'hA5}) begin
      errors++;
      $display("FAIL b2b_restart: got %h expected %h", {BUSY, DONE, RESULT}, {2'b10, 8'hA5});
    end
    for (int i = 0; i < W; i++) begin
      drive(0, 1, 1, 0, 0);
      tick();
      checks++;
      if ({BUSY, DONE, CARRY_OUT, RESULT} !== m_vec()) begin
        errors++;
        $display("FAIL b2b_bit%0d: got %h expected %h", i, {BUSY, DONE, CARRY_OUT, RESULT},
                 m_vec());
      end
    end
    checks++;
    if ({DONE, CARRY_OUT, RESULT} !== {1'b1, 1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL b2b_word: got %h expected %h", {DONE, CARRY_OUT, RESULT},
               {1'b1, 1'b0, 8'hFF});
    end
    drive(0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset_mid_shift();
    logic [W-1:0] word;
    word = 8'h3C;
    drive(1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 1, 0);
      tick();
    end
    #3;
    RESET = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({BUSY, DONE, CARRY_OUT, RESULT} !== 11'h000) begin
      errors++;
      $display("FAIL midshift_reset: got %h expected %h", {BUSY, DONE, CARRY_OUT, RESULT},
               11'h000);
    end
    @(negedge CLK2);
    RESET = 1'b0;
    drive(1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < W; i++) begin
      drive(0, 1, word[i], 1, 0);
      tick();
    end
    checks++;
    if ({DONE, CARRY_OUT, RESULT} !== {1'b1, 1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL midshift_word: got %h expected %h", {DONE, CARRY_OUT, RESULT},
               {1'b1, 1'b1, 8'h3C});
    end
`ifdef PARIDAD_EN
    checks++;
    if (PARIDAD !== 1'b0) begin
      errors++;
      $display("FAIL midshift_parity: got %b expected 0", PARIDAD);
    end
`endif
    drive(0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_random();
    int captures;
    captures = 0;
    for (int n = 0; n < 800; n++) begin
      drive(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 75), 1'($urandom),
            1'($urandom), ($urandom_range(0, 99) < 25));
      tick();
      if (m_mode == 2 && DONE === 1'b1 && m_bits.size() == W) begin
        captures++;
        m_bits.delete();
      end
      checks++;
      if ({BUSY, DONE, CARRY_OUT, RESULT} !== m_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h expected %h", n,
                 {BUSY, DONE, CARRY_OUT, RESULT}, m_vec());
      end
`ifdef PARIDAD_EN
      checks++;
      if (PARIDAD !== ^m_result) begin
        errors++;
        $display("FAIL random_parity%0d: got %b expected %b", n, PARIDAD, ^m_result);
      end
`endif
    end
    checks++;
    if (captures < 5) begin
      errors++;
      $display("FAIL random_coverage: captures %0d expected at least 5", captures);
    end
  endtask

  initial begin
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_basic();
    test_stall();
    test_handshake();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
